pyc_rr_arbiter: RTL and testbench
=================================

// Module: pyc_rr_arbiter
// PURPOSE
//   N-way round-robin arbiter sharing one ready/valid sink (typically a pyc_fifo input) between N producers.
//   Packet-aware: once a requester's beat is offered, the grant is held until the beat with in_last=1 transfers.
//   Zero-latency combinational data path; only the arbitration state is registered.
//   Sits between producers and a shared FIFO/channel; out_id tags each beat with its source index.
// PARAMETERS
//   N      4   number of requesters (>=1; N<=0 is a $fatal at elaboration)
//   WIDTH  32  data width per requester
//   ID_W   (N<=1)?1:$clog2(N)  derived localparam; width of out_id and internal pointers
// PORTS
//   clk        in   1        clock, all state updates on posedge
//   rst        in   1        synchronous reset, active-high
//   in_valid   in   N        per-requester valid
//   in_ready   out  N        per-requester ready; at most one bit set in any cycle
//   in_data    in   N*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//   in_last    in   N        last beat of packet for requester i
//   out_valid  out  1        to sink
//   out_ready  in   1        from sink
//   out_data   out  WIDTH    selected requester data
//   out_last   out  1        selected requester in_last
//   out_id     out  ID_W     index of selected requester
//   busy       out  1        1 while state==LOCK
// BEHAVIOUR
//   State: st in {IDLE, LOCK}, owner[ID_W], rr_ptr[ID_W]. Reset (rst=1 at posedge): st=IDLE, owner=0, rr_ptr=0.
//   While rst=1: in_ready='0, out_valid=0 (forced combinationally); out_data/out_last/out_id don't-care, busy=0.
//   Selection sel:
//     IDLE: first i with in_valid[i]=1 scanning rr_ptr, rr_ptr+1, ... wrapping at N-1 -> 0; if none, sel=rr_ptr.
//     LOCK: sel=owner; other requesters ignored regardless of valid.
//   out_valid=in_valid[sel]; out_data/out_last from sel; out_id=sel; in_ready[i]=out_ready && (i==sel) && !rst.
//   Transfer xfer = out_valid && out_ready (same cycle for requester sel). No buffering; latency 0 cycles.
//   Transitions at posedge (rst=0):
//     IDLE, out_valid=0                -> IDLE, no change
//     IDLE, xfer && out_last           -> IDLE, rr_ptr=sel+1 (wrap N-1->0)
//     IDLE, out_valid && !(xfer&&last) -> LOCK, owner=sel (covers stalled beat and multi-beat packet)
//     LOCK, xfer && out_last           -> IDLE, rr_ptr=owner+1 (wrap)
//     LOCK, otherwise                  -> LOCK
//   Producer rule: once in_valid[i]=1 it holds with stable data until accepted; grant stability relies on it.
//     Bench asserts this rule; behaviour if a locked owner drops valid: arbiter waits in LOCK (no timeout).
//   Fairness: after a packet completes, its source has lowest priority; any continuously-requesting
//     source is granted within N-1 packets.
//   N=1: sel=0 always, rr_ptr stays 0; LOCK still tracked so busy reflects open packets.
//   Reset mid-packet: state returns to IDLE/rr_ptr=0 next cycle; partial packet is not completed by the arbiter.
// TESTING
//   1 Reset: rst=1 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0; after release first grant is id 0.
//   2 RR single-beat: N=4, all valid, in_last=1, out_ready=1 -> out_id sequence 0,1,2,3,0 one beat per cycle.
//   3 Packet lock: req1 3-beat packet (last on beat 3), req2 valid throughout -> ids 1,1,1 then 2; in_ready[2]=0 during lock.
//   4 Backpressure: req0 valid, out_ready=0 for 3 cycles then req3 raises valid -> busy=1, out_id stays 0, beat accepted when out_ready=1.
//   5 Wrap: rr_ptr=3 (after a grant to id 2), valids on 0 and 3 -> grant 3 then 0.
//   6 Mid-packet reset: rst during LOCK on id 2 -> next cycle busy=0; with valids on 1 and 2, grant goes to 1 (rr_ptr=0 scan).

Source files
------------

// File: rtl/pyc_rr_arbiter_if.sv
// Handshake bundle between N producers, the round-robin arbiter and one shared sink.
// The arbiter takes the slave view; producers/sink models take the master view.
interface pyc_rr_arbiter_if #(
   parameter int N     = 4,
   parameter int WIDTH = 32
);
   localparam int ID_W = (N <= 1) ? 1 : $clog2(N);

   logic [N-1:0]            in_valid;
   logic [N-1:0]            in_ready;
   logic [N-1:0][WIDTH-1:0] in_data;
   logic [N-1:0]            in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_last;
   logic [ID_W-1:0]         out_id;
   logic                    busy;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_id, busy
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_id, busy
   );
endinterface

// File: rtl/pyc_rr_arbiter.sv
// Packet-aware N-way round-robin arbiter with a zero-latency combinational data path.
// Only the grant state (IDLE/LOCK, owner, rr_ptr) is registered.
module pyc_rr_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst,
   pyc_rr_arbiter_if.slave bus
);
   localparam int ID_W = (N <= 1) ? 1 : $clog2(N);

   if (N < 1) begin : g_bad_n
      $fatal(1, "pyc_rr_arbiter: N must be >= 1");
   end

   typedef enum logic {IDLE, LOCK} st_t;

   st_t             st, st_nxt;
   logic [ID_W-1:0] owner, owner_nxt;
   logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0] sel;
   logic            xfer;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
      if (int'(v) >= N - 1) return '0;
      return v + 1'b1;
   endfunction

   // Highest priority is rr_ptr itself; scanning downward lets the nearest valid win.
   always_comb begin
      int idx;
      idx = 0;
      sel = rr_ptr;
      if (st == LOCK) begin
         sel = owner;
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N;
            if (bus.in_valid[idx]) sel = ID_W'(idx);
         end
      end
   end

   assign bus.out_valid = !rst && bus.in_valid[sel];
   assign bus.out_data  = bus.in_data[sel];
   assign bus.out_last  = bus.in_last[sel];
   assign bus.out_id    = sel;
   assign bus.busy      = !rst && (st == LOCK);
   assign xfer          = bus.out_valid && bus.out_ready;

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign bus.in_ready[i] = !rst && bus.out_ready && (sel == ID_W'(i));
   end

   // A stalled single beat also locks, so the grant cannot move before it lands.
   always_comb begin
      st_nxt     = st;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;
      case (st)
         IDLE: begin
            if (xfer && bus.out_last) begin
               rr_ptr_nxt = wrap_inc(sel);
            end else if (bus.out_valid) begin
               st_nxt    = LOCK;
               owner_nxt = sel;
            end
         end
         LOCK: begin
            if (xfer && bus.out_last) begin
               st_nxt     = IDLE;
               rr_ptr_nxt = wrap_inc(owner);
            end
         end
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         st     <= st_nxt;
         owner  <= owner_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end
endmodule

// File: tb/tb_pyc_rr_arbiter.sv
// Directed scenarios plus randomized packet traffic, all checked cycle by cycle
// against a grant/priority model built from the arbitration rules.
module tb_pyc_rr_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pyc_rr_arbiter_if #(.N(N), .WIDTH(W)) bus();
   pyc_rr_arbiter #(.N(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;

   // model: open packet owner (if any) and the source that has top priority next
   bit m_lock;
   int m_owner;
   int m_ptr;

   int         obs_id;
   bit         obs_busy;
   logic [N-1:0] obs_rdy;
   logic [N-1:0] obs_acc;
   bit         rand_on = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int m_sel();
      if (m_lock) return m_owner;
      for (int k = 0; k < N; k++)
         if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return m_ptr;
   endfunction

   // Check outputs mid-cycle against the model, advance the model, then cross the posedge.
   task automatic step();
      int s;
      bit v, x, l;
      logic [N-1:0] er;
      @(negedge clk);
      obs_id   = int'(bus.out_id);
      obs_busy = bus.busy;
      obs_rdy  = bus.in_ready;
      obs_acc  = bus.in_valid & bus.in_ready;
      if (rst) begin
         chk("rst_in_ready", bus.in_ready, '0);
         chk("rst_out_valid", bus.out_valid, 1'b0);
         chk("rst_busy", bus.busy, 1'b0);
         m_lock = 0; m_owner = 0; m_ptr = 0;
      end else begin
         s  = m_sel();
         v  = bus.in_valid[s];
         x  = v && bus.out_ready;
         l  = bus.in_last[s];
         er = '0;
         if (bus.out_ready) er[s] = 1'b1;
         chk("out_valid", bus.out_valid, v);
         chk("in_ready", bus.in_ready, er);
         chk("busy", bus.busy, m_lock);
         if (v) begin
            chk("out_id", bus.out_id, s);
            chk("out_data", bus.out_data, bus.in_data[s]);
            chk("out_last", bus.out_last, l);
         end
         if (x && l) begin
            m_lock = 0;
            m_ptr  = (s + 1) % N;
         end else if (v) begin
            m_lock  = 1;
            m_owner = s;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Producer obligation: an offered, unaccepted beat stays valid with the same data.
   logic [N-1:0]        pend = '0;
   logic [N-1:0][W-1:0] pend_d;
   always @(negedge clk) begin
      if (rand_on)
         for (int i = 0; i < N; i++)
            if (pend[i])
               assert (bus.in_valid[i] && bus.in_data[i] == pend_d[i])
                  else $error("producer %0d dropped an unaccepted beat", i);
      pend   <= rand_on ? (bus.in_valid & ~bus.in_ready) : '0;
      pend_d <= bus.in_data;
   end

   initial begin
      m_lock = 0; m_owner = 0; m_ptr = 0;
      bus.in_valid  = '1;
      bus.in_last   = '1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < N; i++) bus.in_data[i] = 32'hA000 + i;

      // reset held with every requester valid, then plain rotation
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_seq", obs_id, k % N);
      end

      // three-beat packet from 1 holds off 2
      do_reset();
      bus.in_valid = 4'b0110;
      bus.in_last  = 4'b0100;
      bus.in_data[1] = 32'hB1;
      bus.in_data[2] = 32'hC0;
      for (int b = 0; b < 3; b++) begin
         if (b == 2) bus.in_last[1] = 1'b1;
         step();
         chk("pkt_id", obs_id, 1);
         chk("pkt_rdy2", obs_rdy[2], 1'b0);
         bus.in_data[1] = 32'hB2 + b;
      end
      bus.in_valid[1] = 1'b0;
      step();
      chk("pkt_next", obs_id, 2);

      // backpressure locks a stalled beat
      do_reset();
      bus.in_valid  = 4'b0001;
      bus.in_last   = '1;
      bus.out_ready = 1'b0;
      step();
      for (int c = 0; c < 2; c++) begin
         step();
         chk("bp_busy", obs_busy, 1'b1);
         chk("bp_id", obs_id, 0);
      end
      bus.in_valid[3] = 1'b1;
      step();
      chk("bp_hold", obs_id, 0);
      bus.out_ready = 1'b1;
      step();
      chk("bp_accept", obs_acc, 4'b0001);
      bus.in_valid[0] = 1'b0;
      step();
      chk("bp_next", obs_id, 3);

      // pointer wrap from 3 to 0
      do_reset();
      bus.in_valid = 4'b0100;
      step();
      bus.in_valid = 4'b1001;
      step();
      chk("wrap_3", obs_id, 3);
      bus.in_valid[3] = 1'b0;
      step();
      chk("wrap_0", obs_id, 0);

      // reset in the middle of a packet from 2
      do_reset();
      bus.in_valid = 4'b0100;
      bus.in_last  = '0;
      step();
      bus.in_valid = 4'b0110;
      step();
      chk("mid_busy", obs_busy, 1'b1);
      chk("mid_id", obs_id, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("mid_after_busy", obs_busy, 1'b0);
      chk("mid_after_id", obs_id, 1);

      // random packet traffic with random sink stalls
      bus.in_last = '0;
      do_reset();
      rand_on = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         bus.out_ready = ($urandom_range(3) != 0);
         step();
         for (int i = 0; i < N; i++) begin
            if (!bus.in_valid[i] || obs_acc[i]) begin
               bus.in_valid[i] = ($urandom_range(2) != 0);
               bus.in_data[i]  = $urandom;
               bus.in_last[i]  = ($urandom_range(2) == 0);
            end
         end
      end
      rand_on = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
